layer_inter_pingpong_control: RTL and testbench
===============================================

LAYER_INTER_PINGPONG_CONTROL -- requirements
Module: layer_inter_pingpong_control

Interface
REQ-001 Parameter: ADDR_WIDTH, default 9, feature-buffer address width per bank.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  permits the producer (former) layer to start new frames.
REQ-005 layer_former_done  input  1  former layer frame complete; level, rising edge significant.
REQ-006 layer_next_done  input  1  next layer frame complete; level, rising edge significant.
REQ-007 layer_former_enable, layer_former_reset  output  1 each  producer run level; one-cycle start pulse.
REQ-008 layer_next_enable, layer_next_reset  output  1 each  consumer run level; one-cycle start pulse.
REQ-009 rden_a/b_former, wren_a/b_former  input  1 each  producer port strobes.
REQ-010 address_a/b_former  input  ADDR_WIDTH each  producer port addresses.
REQ-011 rden_a/b_next  input  1 each  consumer read strobes.
REQ-012 address_a/b_next  input  ADDR_WIDTH each  consumer read addresses.
REQ-013 bank0_rden_a/b, bank0_wren_a/b, bank1_rden_a/b, bank1_wren_a/b  output  1 each  muxed bank strobes.
REQ-014 bank0_address_a/b, bank1_address_a/b  output  ADDR_WIDTH each  muxed bank addresses.
REQ-015 bank_full  output  2  per-bank full flags, for debug.

Function
REQ-016 State: full[1:0], wr_sel, rd_sel, producer FSM {P_IDLE, P_RUN}, consumer FSM {C_IDLE, C_RUN}; all registered.
REQ-017 P_IDLE -> P_RUN when enable==1 and full[wr_sel]==0; layer_former_enable = (state==P_RUN).
REQ-018 P_RUN -> P_IDLE on rising edge of layer_former_done; same edge sets full[wr_sel]=1 and toggles wr_sel.
REQ-019 C_IDLE -> C_RUN when full[rd_sel]==1; layer_next_enable = (state==C_RUN).
REQ-020 C_RUN -> C_IDLE on rising edge of layer_next_done; same edge clears full[rd_sel] and toggles rd_sel.
REQ-021 Rising edge = signal==1 and one-cycle delayed copy==0; edges outside the matching RUN state are ignored.
REQ-022 xxx_reset = xxx_enable & ~xxx_enable_delayed: exactly one cycle, in the first RUN cycle.
REQ-023 Latency: done edge in cycle t -> full visible t+1 -> other side enters RUN and pulses reset in cycle t+2.
REQ-024 Simultaneous set of full[i] and clear of full[j] (i!=j) both take effect; same-bank set/clear cannot occur and is not handled.
REQ-025 Bank wr_sel in P_RUN carries all former strobes/addresses; bank rd_sel in C_RUN carries next rden/address with wren forced 0.
REQ-026 Any bank not selected by a RUN state drives all strobes and addresses 0.
REQ-027 enable dropping mid-frame does not abort P_RUN; it only blocks the next P_IDLE -> P_RUN.
REQ-028 Both banks full: producer holds P_IDLE (backpressure); both empty: consumer holds C_IDLE.

Reset
REQ-029 reset: full=0, wr_sel=0, rd_sel=0, P_IDLE, C_IDLE, delay registers 0; all outputs 0 the following cycle.
REQ-030 Reset mid-frame discards in-flight frames without a done edge; no start pulse fires during or on exit from reset.

Structure
REQ-031 Shared package holds the FSM state encodings and the ADDR_WIDTH default.
REQ-032 One sub-module, edge_pulse_detect (delay register + rising-edge AND), instantiated four times (two done edges, two start pulses).

Verification
REQ-033 Reset, enable=1 -> cycle 1 P_RUN, layer_former_reset=1 for exactly 1 cycle, bank0 follows former address_a=0x1A5.
REQ-034 former_done edge at t -> full=01 at t+1, layer_next_reset pulse at t+2, bank0 carries address_a_next=0x012, wren=0; producer restarts on bank1 at t+2.
REQ-035 Two producer frames with next_done withheld -> full=11, layer_former_enable held 0 until next_done edge frees bank0.
REQ-036 former_done and next_done edges in the same cycle -> full goes 01->10 in one cycle, both pointers toggle.
REQ-037 former_done held high 20 cycles -> only one frame counted; reset asserted mid-C_RUN -> all outputs 0, full=00, no spurious pulse after release.

Source files
------------

// File: rtl/layer_inter_pingpong_control_pkg.sv
// Shared definitions for the layer-to-layer ping-pong buffer controller.
// Holds the producer/consumer FSM encodings, the bank count and the default
// feature-buffer address width used by the top-level parameter.
package layer_inter_pingpong_control_pkg;

   localparam int DEFAULT_ADDR_WIDTH = 9;
   localparam int NUM_BANKS          = 2;

   typedef enum logic {
      P_IDLE = 1'b0,
      P_RUN  = 1'b1
   } producer_state_t;

   typedef enum logic {
      C_IDLE = 1'b0,
      C_RUN  = 1'b1
   } consumer_state_t;

endpackage

// File: rtl/edge_pulse_detect.sv
// Rising-edge detector: one delay register plus an AND with the inverted
// delayed copy.
// Ports:
//    clock  rising-edge clock
//    reset  synchronous active-high reset, clears the delay register
//    sig    level input to watch
//    pulse  high in every cycle where sig==1 and its previous value was 0
module edge_pulse_detect (
   input  logic clock,
   input  logic reset,
   input  logic sig,
   output logic pulse
);

   logic sig_delayed_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         sig_delayed_reg <= 1'b0;
      end else begin
         sig_delayed_reg <= sig;
      end
   end

   assign pulse = sig & ~sig_delayed_reg;

endmodule

// File: rtl/layer_inter_pingpong_control.sv
// Ping-pong controller between a producer (former) layer and a consumer
// (next) layer sharing two feature-buffer banks.
// The producer fills bank wr_sel while the consumer drains bank rd_sel; each
// finished frame marks its bank full, each consumed frame marks it empty.
// Ports:
//    clock, reset                      clock / synchronous active-high reset
//    enable                            allows the producer to start new frames
//    layer_former_done/next_done       frame-complete levels (rising edge used)
//    layer_former_enable/reset         producer run level / start pulse
//    layer_next_enable/reset           consumer run level / start pulse
//    rden/wren/address_a/b_former      producer port strobes and addresses
//    rden/address_a/b_next             consumer read strobes and addresses
//    bank0_*/bank1_*                   muxed per-bank strobes and addresses
//    bank_full                         per-bank full flags
module layer_inter_pingpong_control
   import layer_inter_pingpong_control_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  layer_former_done,
   input  logic                  layer_next_done,
   output logic                  layer_former_enable,
   output logic                  layer_former_reset,
   output logic                  layer_next_enable,
   output logic                  layer_next_reset,
   input  logic                  rden_a_former,
   input  logic                  rden_b_former,
   input  logic                  wren_a_former,
   input  logic                  wren_b_former,
   input  logic [ADDR_WIDTH-1:0] address_a_former,
   input  logic [ADDR_WIDTH-1:0] address_b_former,
   input  logic                  rden_a_next,
   input  logic                  rden_b_next,
   input  logic [ADDR_WIDTH-1:0] address_a_next,
   input  logic [ADDR_WIDTH-1:0] address_b_next,
   output logic                  bank0_rden_a,
   output logic                  bank0_rden_b,
   output logic                  bank0_wren_a,
   output logic                  bank0_wren_b,
   output logic                  bank1_rden_a,
   output logic                  bank1_rden_b,
   output logic                  bank1_wren_a,
   output logic                  bank1_wren_b,
   output logic [ADDR_WIDTH-1:0] bank0_address_a,
   output logic [ADDR_WIDTH-1:0] bank0_address_b,
   output logic [ADDR_WIDTH-1:0] bank1_address_a,
   output logic [ADDR_WIDTH-1:0] bank1_address_b,
   output logic [1:0]            bank_full
);

   producer_state_t p_state_reg, p_state_next;
   consumer_state_t c_state_reg, c_state_next;
   logic [1:0]      full_reg, full_next;
   logic            wr_sel_reg, wr_sel_next;
   logic            rd_sel_reg, rd_sel_next;

   logic former_done_edge, next_done_edge;
   logic former_frame_done, next_frame_done;

   edge_pulse_detect u_former_done (
      .clock (clock), .reset (reset), .sig (layer_former_done), .pulse (former_done_edge)
   );
   edge_pulse_detect u_next_done (
      .clock (clock), .reset (reset), .sig (layer_next_done), .pulse (next_done_edge)
   );
   edge_pulse_detect u_former_start (
      .clock (clock), .reset (reset), .sig (layer_former_enable), .pulse (layer_former_reset)
   );
   edge_pulse_detect u_next_start (
      .clock (clock), .reset (reset), .sig (layer_next_enable), .pulse (layer_next_reset)
   );

   // Done edges only count while the matching side is actually running.
   assign former_frame_done = (p_state_reg == P_RUN) && former_done_edge;
   assign next_frame_done   = (c_state_reg == C_RUN) && next_done_edge;

   always_ff @(posedge clock) begin
      if (reset) begin
         p_state_reg <= P_IDLE;
         c_state_reg <= C_IDLE;
         full_reg    <= 2'b00;
         wr_sel_reg  <= 1'b0;
         rd_sel_reg  <= 1'b0;
      end else begin
         p_state_reg <= p_state_next;
         c_state_reg <= c_state_next;
         full_reg    <= full_next;
         wr_sel_reg  <= wr_sel_next;
         rd_sel_reg  <= rd_sel_next;
      end
   end

   // Producer and consumer always own different banks (a running producer's
   // bank is empty, a running consumer's bank is full), so the set and clear
   // below never hit the same bit.
   always_comb begin
      p_state_next = p_state_reg;
      c_state_next = c_state_reg;
      full_next    = full_reg;
      wr_sel_next  = wr_sel_reg;
      rd_sel_next  = rd_sel_reg;

      case (p_state_reg)
         P_IDLE: begin
            if (enable && !full_reg[wr_sel_reg]) begin
               p_state_next = P_RUN;
            end
         end
         P_RUN: begin
            if (former_frame_done) begin
               p_state_next          = P_IDLE;
               full_next[wr_sel_reg] = 1'b1;
               wr_sel_next           = ~wr_sel_reg;
            end
         end
         default: p_state_next = P_IDLE;
      endcase

      case (c_state_reg)
         C_IDLE: begin
            if (full_reg[rd_sel_reg]) begin
               c_state_next = C_RUN;
            end
         end
         C_RUN: begin
            if (next_frame_done) begin
               c_state_next          = C_IDLE;
               full_next[rd_sel_reg] = 1'b0;
               rd_sel_next           = ~rd_sel_reg;
            end
         end
         default: c_state_next = C_IDLE;
      endcase
   end

   assign layer_former_enable = (p_state_reg == P_RUN);
   assign layer_next_enable   = (c_state_reg == C_RUN);
   assign bank_full           = full_reg;

   logic [NUM_BANKS-1:0]  producer_owns, consumer_owns;
   logic [NUM_BANKS-1:0]  mux_rden_a, mux_rden_b, mux_wren_a, mux_wren_b;
   logic [ADDR_WIDTH-1:0] mux_address_a [NUM_BANKS];
   logic [ADDR_WIDTH-1:0] mux_address_b [NUM_BANKS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
         localparam logic BANK_ID = (gi == 1);

         assign producer_owns[gi] = layer_former_enable && (wr_sel_reg == BANK_ID);
         assign consumer_owns[gi] = layer_next_enable   && (rd_sel_reg == BANK_ID);

         // The consumer only reads, so its write strobes are tied low.
         assign mux_rden_a[gi] = producer_owns[gi] ? rden_a_former :
                                 consumer_owns[gi] ? rden_a_next : 1'b0;
         assign mux_rden_b[gi] = producer_owns[gi] ? rden_b_former :
                                 consumer_owns[gi] ? rden_b_next : 1'b0;
         assign mux_wren_a[gi] = producer_owns[gi] ? wren_a_former : 1'b0;
         assign mux_wren_b[gi] = producer_owns[gi] ? wren_b_former : 1'b0;
         assign mux_address_a[gi] = producer_owns[gi] ? address_a_former :
                                    consumer_owns[gi] ? address_a_next : '0;
         assign mux_address_b[gi] = producer_owns[gi] ? address_b_former :
                                    consumer_owns[gi] ? address_b_next : '0;
      end
   endgenerate

   assign bank0_rden_a    = mux_rden_a[0];
   assign bank0_rden_b    = mux_rden_b[0];
   assign bank0_wren_a    = mux_wren_a[0];
   assign bank0_wren_b    = mux_wren_b[0];
   assign bank0_address_a = mux_address_a[0];
   assign bank0_address_b = mux_address_b[0];
   assign bank1_rden_a    = mux_rden_a[1];
   assign bank1_rden_b    = mux_rden_b[1];
   assign bank1_wren_a    = mux_wren_a[1];
   assign bank1_wren_b    = mux_wren_b[1];
   assign bank1_address_a = mux_address_a[1];
   assign bank1_address_b = mux_address_b[1];

endmodule

// File: tb/tb_layer_inter_pingpong_control.sv
// Scoreboard bench for layer_inter_pingpong_control. The stimulus process
// queues expected output values tagged with the cycle they must appear in;
// a monitor samples the DUT on every falling edge and retires matching entries.
module tb_layer_inter_pingpong_control;

   localparam int AW = 9;

   // Observed-signal indices.
   localparam int S_PEN  = 0;
   localparam int S_PRST = 1;
   localparam int S_NEN  = 2;
   localparam int S_NRST = 3;
   localparam int S_FULL = 4;
   localparam int S_B0   = 5;   // bank0: ra, wa, aa, rb, wb, ab at S_B0+0..5
   localparam int S_B1   = 11;  // bank1: same layout
   localparam int NSIG   = 17;

   localparam int M_IDLE = 0;
   localparam int M_PROD = 1;
   localparam int M_CONS = 2;

   string sig_name [NSIG] = '{"former_enable", "former_reset", "next_enable", "next_reset",
                              "bank_full",
                              "bank0_rden_a", "bank0_wren_a", "bank0_address_a",
                              "bank0_rden_b", "bank0_wren_b", "bank0_address_b",
                              "bank1_rden_a", "bank1_wren_a", "bank1_address_a",
                              "bank1_rden_b", "bank1_wren_b", "bank1_address_b"};

   logic          clock, reset, enable, layer_former_done, layer_next_done;
   logic          layer_former_enable, layer_former_reset, layer_next_enable, layer_next_reset;
   logic          rden_a_former, rden_b_former, wren_a_former, wren_b_former;
   logic [AW-1:0] address_a_former, address_b_former;
   logic          rden_a_next, rden_b_next;
   logic [AW-1:0] address_a_next, address_b_next;
   logic          bank0_rden_a, bank0_rden_b, bank0_wren_a, bank0_wren_b;
   logic          bank1_rden_a, bank1_rden_b, bank1_wren_a, bank1_wren_b;
   logic [AW-1:0] bank0_address_a, bank0_address_b, bank1_address_a, bank1_address_b;
   logic [1:0]    bank_full;

   layer_inter_pingpong_control #(.ADDR_WIDTH(AW)) dut (
      .clock               (clock),
      .reset               (reset),
      .enable              (enable),
      .layer_former_done   (layer_former_done),
      .layer_next_done     (layer_next_done),
      .layer_former_enable (layer_former_enable),
      .layer_former_reset  (layer_former_reset),
      .layer_next_enable   (layer_next_enable),
      .layer_next_reset    (layer_next_reset),
      .rden_a_former       (rden_a_former),
      .rden_b_former       (rden_b_former),
      .wren_a_former       (wren_a_former),
      .wren_b_former       (wren_b_former),
      .address_a_former    (address_a_former),
      .address_b_former    (address_b_former),
      .rden_a_next         (rden_a_next),
      .rden_b_next         (rden_b_next),
      .address_a_next      (address_a_next),
      .address_b_next      (address_b_next),
      .bank0_rden_a        (bank0_rden_a),
      .bank0_rden_b        (bank0_rden_b),
      .bank0_wren_a        (bank0_wren_a),
      .bank0_wren_b        (bank0_wren_b),
      .bank1_rden_a        (bank1_rden_a),
      .bank1_rden_b        (bank1_rden_b),
      .bank1_wren_a        (bank1_wren_a),
      .bank1_wren_b        (bank1_wren_b),
      .bank0_address_a     (bank0_address_a),
      .bank0_address_b     (bank0_address_b),
      .bank1_address_a     (bank1_address_a),
      .bank1_address_b     (bank1_address_b),
      .bank_full           (bank_full)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int sig;
      int val;
   } exp_t;

   exp_t sb [$];
   int   checks_total  = 0;
   int   checks_passed = 0;

   function automatic int observe(input int s);
      case (s)
         S_PEN:     return int'(layer_former_enable);
         S_PRST:    return int'(layer_former_reset);
         S_NEN:     return int'(layer_next_enable);
         S_NRST:    return int'(layer_next_reset);
         S_FULL:    return int'(bank_full);
         S_B0 + 0:  return int'(bank0_rden_a);
         S_B0 + 1:  return int'(bank0_wren_a);
         S_B0 + 2:  return int'(bank0_address_a);
         S_B0 + 3:  return int'(bank0_rden_b);
         S_B0 + 4:  return int'(bank0_wren_b);
         S_B0 + 5:  return int'(bank0_address_b);
         S_B1 + 0:  return int'(bank1_rden_a);
         S_B1 + 1:  return int'(bank1_wren_a);
         S_B1 + 2:  return int'(bank1_address_a);
         S_B1 + 3:  return int'(bank1_rden_b);
         S_B1 + 4:  return int'(bank1_wren_b);
         S_B1 + 5:  return int'(bank1_address_b);
         default:   return -1;
      endcase
   endfunction

   // Monitor: retire every expectation due in the current cycle.
   always @(negedge clock) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc <= cyc) begin
            int got;
            got = observe(sb[i].sig);
            checks_total = checks_total + 1;
            if (sb[i].cyc < cyc) begin
               $display("FAIL %s cycle %0d: expectation never sampled, required 0x%0h",
                        sig_name[sb[i].sig], sb[i].cyc, sb[i].val);
            end else if (got != sb[i].val) begin
               $display("FAIL %s cycle %0d: got 0x%0h, required 0x%0h",
                        sig_name[sb[i].sig], cyc, got, sb[i].val);
            end else begin
               checks_passed = checks_passed + 1;
               $display("check %s cycle %0d = 0x%0h ok", sig_name[sb[i].sig], cyc, got);
            end
            sb.delete(i);
         end
      end
   end

   task automatic expect_at(input int off, input int s, input int v);
      exp_t e;
      e.cyc = cyc + off;
      e.sig = s;
      e.val = v;
      sb.push_back(e);
   endtask

   // Expected contents of one bank: idle (all zero), producer-owned, or
   // consumer-owned, based on the constant port stimulus below.
   task automatic expect_bank(input int off, input int bank, input int mode);
      int base;
      base = (bank == 0) ? S_B0 : S_B1;
      case (mode)
         M_PROD: begin
            expect_at(off, base + 0, 1); expect_at(off, base + 1, 1); expect_at(off, base + 2, 'h1A5);
            expect_at(off, base + 3, 0); expect_at(off, base + 4, 1); expect_at(off, base + 5, 'h0C3);
         end
         M_CONS: begin
            expect_at(off, base + 0, 1); expect_at(off, base + 1, 0); expect_at(off, base + 2, 'h012);
            expect_at(off, base + 3, 1); expect_at(off, base + 4, 0); expect_at(off, base + 5, 'h034);
         end
         default: begin
            for (int k = 0; k < 6; k++) expect_at(off, base + k, 0);
         end
      endcase
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clock);
         #1;
      end
   endtask

   initial begin
      reset             = 1'b1;
      enable            = 1'b0;
      layer_former_done = 1'b0;
      layer_next_done   = 1'b0;
      rden_a_former     = 1'b1;
      wren_a_former     = 1'b1;
      address_a_former  = 9'h1A5;
      rden_b_former     = 1'b0;
      wren_b_former     = 1'b1;
      address_b_former  = 9'h0C3;
      rden_a_next       = 1'b1;
      address_a_next    = 9'h012;
      rden_b_next       = 1'b1;
      address_b_next    = 9'h034;

      tick(3);
      // In reset: everything low even though port strobes are active.
      expect_at(0, S_PEN, 0); expect_at(0, S_PRST, 0); expect_at(0, S_NEN, 0);
      expect_at(0, S_NRST, 0); expect_at(0, S_FULL, 0);
      expect_bank(0, 0, M_IDLE); expect_bank(0, 1, M_IDLE);

      // Release reset with enable: producer runs on bank0 one cycle later.
      tick(1);
      reset  = 1'b0;
      enable = 1'b1;
      expect_at(0, S_PEN, 0); expect_at(0, S_PRST, 0);
      expect_at(1, S_PEN, 1); expect_at(1, S_PRST, 1); expect_at(1, S_NEN, 0);
      expect_bank(1, 0, M_PROD); expect_bank(1, 1, M_IDLE);
      expect_at(2, S_PEN, 1); expect_at(2, S_PRST, 0);

      // First frame done: bank0 full, consumer on bank0, producer on bank1.
      tick(5);
      layer_former_done = 1'b1;
      expect_at(0, S_FULL, 0); expect_at(0, S_PEN, 1);
      expect_at(1, S_FULL, 1); expect_at(1, S_PEN, 0); expect_at(1, S_NEN, 0);
      expect_bank(1, 0, M_IDLE); expect_bank(1, 1, M_IDLE);
      expect_at(2, S_NEN, 1); expect_at(2, S_NRST, 1); expect_at(2, S_PEN, 1); expect_at(2, S_PRST, 1);
      expect_bank(2, 0, M_CONS); expect_bank(2, 1, M_PROD);
      expect_at(3, S_NRST, 0); expect_at(3, S_PRST, 0);
      tick(1);
      layer_former_done = 1'b0;

      // Second frame with consumer still busy: both full, producer stalls.
      tick(5);
      layer_former_done = 1'b1;
      expect_at(1, S_FULL, 3); expect_at(1, S_PEN, 0);
      expect_at(2, S_PEN, 0); expect_at(2, S_PRST, 0);
      expect_bank(2, 0, M_CONS); expect_bank(2, 1, M_IDLE);
      expect_at(5, S_PEN, 0); expect_at(5, S_NEN, 1); expect_at(5, S_FULL, 3);
      tick(1);
      layer_former_done = 1'b0;

      // Consumer finishes bank0: producer back on bank0, consumer on bank1.
      tick(5);
      layer_next_done = 1'b1;
      expect_at(1, S_FULL, 2); expect_at(1, S_NEN, 0); expect_at(1, S_PEN, 0);
      expect_at(2, S_PEN, 1); expect_at(2, S_PRST, 1); expect_at(2, S_NEN, 1); expect_at(2, S_NRST, 1);
      expect_bank(2, 0, M_PROD); expect_bank(2, 1, M_CONS);
      tick(1);
      layer_next_done = 1'b0;

      // Simultaneous done edges: full 10 -> 01, both pointers toggle.
      tick(4);
      layer_former_done = 1'b1;
      layer_next_done   = 1'b1;
      expect_at(0, S_FULL, 2);
      expect_at(1, S_FULL, 1); expect_at(1, S_PEN, 0); expect_at(1, S_NEN, 0);
      expect_at(2, S_PEN, 1); expect_at(2, S_PRST, 1); expect_at(2, S_NEN, 1); expect_at(2, S_NRST, 1);
      expect_bank(2, 0, M_CONS); expect_bank(2, 1, M_PROD);
      tick(1);
      layer_former_done = 1'b0;
      layer_next_done   = 1'b0;

      // Simultaneous again: full 01 -> 10.
      tick(4);
      layer_former_done = 1'b1;
      layer_next_done   = 1'b1;
      expect_at(0, S_FULL, 1);
      expect_at(1, S_FULL, 2);
      expect_at(2, S_PEN, 1); expect_at(2, S_NEN, 1);
      expect_bank(2, 0, M_PROD); expect_bank(2, 1, M_CONS);
      tick(1);
      layer_former_done = 1'b0;
      layer_next_done   = 1'b0;

      // former_done held high 20 cycles: counted once only.
      tick(4);
      layer_former_done = 1'b1;
      expect_at(1, S_FULL, 3); expect_at(1, S_PEN, 0);
      tick(3);
      layer_next_done = 1'b1;
      expect_at(1, S_FULL, 1);
      expect_at(2, S_PEN, 1); expect_at(2, S_PRST, 1); expect_at(2, S_NEN, 1); expect_at(2, S_NRST, 1);
      expect_bank(2, 0, M_CONS); expect_bank(2, 1, M_PROD);
      expect_at(3, S_PRST, 0);
      expect_at(7, S_PEN, 1); expect_at(7, S_FULL, 1);
      tick(1);
      layer_next_done = 1'b0;
      tick(16);
      layer_former_done = 1'b0;
      expect_at(0, S_PEN, 1); expect_at(0, S_FULL, 1);
      expect_at(1, S_PEN, 1); expect_at(1, S_FULL, 1);

      // Reset while the consumer runs: everything clears, no pulse on exit.
      tick(3);
      reset = 1'b1;
      expect_at(0, S_NEN, 1); expect_at(0, S_PEN, 1);
      expect_at(1, S_NEN, 0); expect_at(1, S_PEN, 0); expect_at(1, S_FULL, 0);
      expect_at(1, S_NRST, 0); expect_at(1, S_PRST, 0);
      expect_bank(1, 0, M_IDLE); expect_bank(1, 1, M_IDLE);
      tick(3);
      reset  = 1'b0;
      enable = 1'b0;
      for (int k = 0; k < 4; k++) begin
         expect_at(k, S_PRST, 0); expect_at(k, S_NRST, 0);
         expect_at(k, S_PEN, 0); expect_at(k, S_NEN, 0); expect_at(k, S_FULL, 0);
      end

      // Fresh start after reset lands on bank0 again.
      tick(3);
      enable = 1'b1;
      expect_at(1, S_PEN, 1); expect_at(1, S_PRST, 1); expect_at(1, S_NEN, 0);
      expect_bank(1, 0, M_PROD); expect_bank(1, 1, M_IDLE);
      expect_at(2, S_PRST, 0);

      tick(4);
      checks_total = checks_total + 1;
      if (sb.size() != 0) begin
         $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
      end else begin
         checks_passed = checks_passed + 1;
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
